// File: rtl/midi_voice_alloc.sv
// Polyphonic MIDI voice allocator: filters events by channel, scans the voice pool one
// voice per cycle, then retriggers, allocates, steals or releases a voice for synth_engine.
module midi_voice_alloc #(
    parameter int VOICES   = 8,
    parameter int V_WIDTH  = (VOICES > 1) ? $clog2(VOICES) : 1,
    parameter int CHANNELS = 1,
    parameter int STEAL_EN = 1
) (
    input  logic               CLOCK_25,
    input  logic               iRST,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic               ev_on,
    input  logic [3:0]         ev_ch,
    input  logic [6:0]         ev_key,
    input  logic [6:0]         ev_vel,
    input  logic [3:0]         base_ch,
    input  logic [VOICES-1:0]  voice_free,
    output logic               note_on,
    output logic               note_off,
    output logic               steal,
    output logic               off_note_error,
    output logic [V_WIDTH-1:0] cur_key_adr,
    output logic [7:0]         cur_key_val,
    output logic [7:0]         cur_vel_on,
    output logic [7:0]         cur_vel_off,
    output logic [3:0]         cur_ch,
    output logic [VOICES-1:0]  keys_on,
    output logic [V_WIDTH:0]   active_keys
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);

    function automatic logic [V_WIDTH:0] popcount(input logic [VOICES-1:0] vec);
        logic [V_WIDTH:0] cnt;
        cnt = {(V_WIDTH + 1){1'b0}};
        for (int i = 0; i < VOICES; i++) begin
            cnt = cnt + {{V_WIDTH{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    state_t              state_q, state_d;
    logic [V_WIDTH-1:0]  idx_q, idx_d;
    logic                ev_on_q, ev_on_d;
    logic [3:0]          ev_ch_q, ev_ch_d;
    logic [6:0]          ev_key_q, ev_key_d;
    logic [6:0]          ev_vel_q, ev_vel_d;
    logic                match_hit_q, match_hit_d, free_hit_q, free_hit_d, old_hit_q, old_hit_d;
    logic [V_WIDTH-1:0]  match_idx_q, match_idx_d, free_idx_q, free_idx_d, old_idx_q, old_idx_d;
    logic [VOICES-1:0]   keys_on_q, keys_on_d;
    logic [6:0]          key_mem_q [VOICES];
    logic [6:0]          key_mem_d [VOICES];
    logic [3:0]          ch_mem_q [VOICES];
    logic [3:0]          ch_mem_d [VOICES];
    logic [V_WIDTH-1:0]  rank_q [VOICES];
    logic [V_WIDTH-1:0]  rank_d [VOICES];
    logic                ready_q, ready_d;
    logic                note_on_q, note_on_d, note_off_q, note_off_d;
    logic                steal_q, steal_d, err_q, err_d;
    logic [V_WIDTH-1:0]  cur_key_adr_q, cur_key_adr_d;
    logic [7:0]          cur_key_val_q, cur_key_val_d, cur_vel_on_q, cur_vel_on_d;
    logic [7:0]          cur_vel_off_q, cur_vel_off_d;
    logic [3:0]          cur_ch_q, cur_ch_d;
    logic [V_WIDTH:0]    active_keys_q, active_keys_d;

    logic                accept_s, in_range_s, commit_s;
    logic [3:0]          ch_off_s;
    logic                hit_match_s, hit_free_s, hit_old_s;
    logic                m_hit_s, f_hit_s, o_hit_s;
    logic [V_WIDTH-1:0]  m_idx_s, f_idx_s, o_idx_s;
    logic                alloc_s, release_s, steal_s, err_s;
    logic [V_WIDTH-1:0]  alloc_idx_s;

    assign accept_s   = ev_valid & ready_q;
    assign ch_off_s   = ev_ch - base_ch;
    assign in_range_s = (5'(ch_off_s) < 5'(CHANNELS));
    assign commit_s   = (state_q == S_SCAN) && (idx_q == LAST_IDX);

    assign hit_match_s = keys_on_q[idx_q] & (key_mem_q[idx_q] == ev_key_q) & (ch_mem_q[idx_q] == ev_ch_q);
    assign hit_free_s  = voice_free[idx_q] & ~keys_on_q[idx_q];
    assign hit_old_s   = (rank_q[idx_q] == LAST_IDX);

    // Running scan results including the voice under the index this cycle; earlier hits win.
    assign m_hit_s = match_hit_q | hit_match_s;
    assign m_idx_s = match_hit_q ? match_idx_q : idx_q;
    assign f_hit_s = free_hit_q | hit_free_s;
    assign f_idx_s = free_hit_q ? free_idx_q : idx_q;
    assign o_hit_s = old_hit_q | hit_old_s;
    assign o_idx_s = old_hit_q ? old_idx_q : idx_q;

    // Commit decision: retrigger > free voice > steal oldest > error.
    always_comb begin
        alloc_s     = 1'b0;
        alloc_idx_s = {V_WIDTH{1'b0}};
        release_s   = 1'b0;
        steal_s     = 1'b0;
        err_s       = 1'b0;
        if (ev_on_q) begin
            if (m_hit_s) begin
                alloc_s     = 1'b1;
                alloc_idx_s = m_idx_s;
            end else if (f_hit_s) begin
                alloc_s     = 1'b1;
                alloc_idx_s = f_idx_s;
            end else if ((STEAL_EN != 0) && o_hit_s) begin
                alloc_s     = 1'b1;
                alloc_idx_s = o_idx_s;
                steal_s     = 1'b1;
            end else begin
                err_s = 1'b1;
            end
        end else begin
            if (m_hit_s) begin
                release_s   = 1'b1;
                alloc_idx_s = m_idx_s;
            end else begin
                err_s = 1'b1;
            end
        end
    end

    // Next-state for the FSM, the voice stores and every registered output.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ev_on_d       = ev_on_q;
        ev_ch_d       = ev_ch_q;
        ev_key_d      = ev_key_q;
        ev_vel_d      = ev_vel_q;
        match_hit_d   = match_hit_q;
        match_idx_d   = match_idx_q;
        free_hit_d    = free_hit_q;
        free_idx_d    = free_idx_q;
        old_hit_d     = old_hit_q;
        old_idx_d     = old_idx_q;
        keys_on_d     = keys_on_q;
        key_mem_d     = key_mem_q;
        ch_mem_d      = ch_mem_q;
        rank_d        = rank_q;
        note_on_d     = 1'b0;
        note_off_d    = 1'b0;
        steal_d       = 1'b0;
        err_d         = 1'b0;
        cur_key_adr_d = cur_key_adr_q;
        cur_key_val_d = cur_key_val_q;
        cur_vel_on_d  = cur_vel_on_q;
        cur_vel_off_d = cur_vel_off_q;
        cur_ch_d      = cur_ch_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    ev_on_d     = ev_on & (ev_vel != 7'd0);
                    ev_ch_d     = ev_ch;
                    ev_key_d    = ev_key;
                    ev_vel_d    = ev_vel;
                    match_hit_d = 1'b0;
                    free_hit_d  = 1'b0;
                    old_hit_d   = 1'b0;
                    idx_d       = {V_WIDTH{1'b0}};
                    state_d     = in_range_s ? S_SCAN : S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                match_hit_d = m_hit_s;
                match_idx_d = m_idx_s;
                free_hit_d  = f_hit_s;
                free_idx_d  = f_idx_s;
                old_hit_d   = o_hit_s;
                old_idx_d   = o_idx_s;
                if (idx_q == LAST_IDX) begin
                    state_d = S_COMMIT;
                end else begin
                    idx_d = idx_q + V_WIDTH'(1);
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (commit_s) begin
            note_on_d  = alloc_s;
            note_off_d = release_s;
            steal_d    = steal_s;
            err_d      = err_s;
            if (alloc_s) begin
                keys_on_d[alloc_idx_s] = 1'b1;
                key_mem_d[alloc_idx_s] = ev_key_q;
                ch_mem_d[alloc_idx_s]  = ev_ch_q;
                cur_key_adr_d = alloc_idx_s;
                cur_key_val_d = {1'b0, ev_key_q};
                cur_vel_on_d  = {1'b0, ev_vel_q};
                cur_ch_d      = ev_ch_q;
                // Younger voices age by one; the allocated voice becomes the newest.
                for (int i = 0; i < VOICES; i++) begin
                    if (rank_q[i] < rank_q[alloc_idx_s]) begin
                        rank_d[i] = rank_q[i] + V_WIDTH'(1);
                    end else begin
                        rank_d[i] = rank_q[i];
                    end
                end
                rank_d[alloc_idx_s] = {V_WIDTH{1'b0}};
            end else if (release_s) begin
                keys_on_d[alloc_idx_s] = 1'b0;
                cur_key_adr_d = alloc_idx_s;
                cur_vel_off_d = {1'b0, ev_vel_q};
                cur_ch_d      = ev_ch_q;
            end else begin
                keys_on_d = keys_on_q;
            end
        end else begin
            keys_on_d = keys_on_q;
        end

        active_keys_d = popcount(keys_on_d);
        ready_d       = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLOCK_25) begin
        if (iRST) begin
            state_q       <= S_IDLE;
            idx_q         <= {V_WIDTH{1'b0}};
            ev_on_q       <= 1'b0;
            ev_ch_q       <= 4'd0;
            ev_key_q      <= 7'd0;
            ev_vel_q      <= 7'd0;
            match_hit_q   <= 1'b0;
            match_idx_q   <= {V_WIDTH{1'b0}};
            free_hit_q    <= 1'b0;
            free_idx_q    <= {V_WIDTH{1'b0}};
            old_hit_q     <= 1'b0;
            old_idx_q     <= {V_WIDTH{1'b0}};
            keys_on_q     <= {VOICES{1'b0}};
            for (int i = 0; i < VOICES; i++) begin
                key_mem_q[i] <= 7'd0;
                ch_mem_q[i]  <= 4'd0;
                rank_q[i]    <= V_WIDTH'(i);
            end
            ready_q       <= 1'b0;
            note_on_q     <= 1'b0;
            note_off_q    <= 1'b0;
            steal_q       <= 1'b0;
            err_q         <= 1'b0;
            cur_key_adr_q <= {V_WIDTH{1'b0}};
            cur_key_val_q <= 8'd0;
            cur_vel_on_q  <= 8'd0;
            cur_vel_off_q <= 8'd0;
            cur_ch_q      <= 4'd0;
            active_keys_q <= {(V_WIDTH + 1){1'b0}};
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            ev_on_q       <= ev_on_d;
            ev_ch_q       <= ev_ch_d;
            ev_key_q      <= ev_key_d;
            ev_vel_q      <= ev_vel_d;
            match_hit_q   <= match_hit_d;
            match_idx_q   <= match_idx_d;
            free_hit_q    <= free_hit_d;
            free_idx_q    <= free_idx_d;
            old_hit_q     <= old_hit_d;
            old_idx_q     <= old_idx_d;
            keys_on_q     <= keys_on_d;
            key_mem_q     <= key_mem_d;
            ch_mem_q      <= ch_mem_d;
            rank_q        <= rank_d;
            ready_q       <= ready_d;
            note_on_q     <= note_on_d;
            note_off_q    <= note_off_d;
            steal_q       <= steal_d;
            err_q         <= err_d;
            cur_key_adr_q <= cur_key_adr_d;
            cur_key_val_q <= cur_key_val_d;
            cur_vel_on_q  <= cur_vel_on_d;
            cur_vel_off_q <= cur_vel_off_d;
            cur_ch_q      <= cur_ch_d;
            active_keys_q <= active_keys_d;
        end
    end

    assign ev_ready       = ready_q;
    assign note_on        = note_on_q;
    assign note_off       = note_off_q;
    assign steal          = steal_q;
    assign off_note_error = err_q;
    assign cur_key_adr    = cur_key_adr_q;
    assign cur_key_val    = cur_key_val_q;
    assign cur_vel_on     = cur_vel_on_q;
    assign cur_vel_off    = cur_vel_off_q;
    assign cur_ch         = cur_ch_q;
    assign keys_on        = keys_on_q;
    assign active_keys    = active_keys_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Bench for midi_voice_alloc: a stealing and a non-stealing instance share one event bus
// and are compared against a least-recently-allocated list model.
module tb_midi_voice_alloc;
    localparam int NV  = 8;
    localparam int NCH = 2;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       rst, ev_valid, ev_on;
    logic [3:0] ev_ch, base_ch;
    logic [6:0] ev_key, ev_vel;
    logic [7:0] voice_free;
    logic [1:0] rdy, non, noff, stl, err;
    logic [2:0] adr  [2];
    logic [7:0] kval [2];
    logic [7:0] von  [2];
    logic [7:0] voff [2];
    logic [3:0] cch  [2];
    logic [7:0] kon  [2];
    logic [3:0] act  [2];

    midi_voice_alloc #(.VOICES(NV), .CHANNELS(NCH), .STEAL_EN(1)) u_dut_steal (
        .CLOCK_25(clk), .iRST(rst), .ev_valid(ev_valid), .ev_ready(rdy[0]), .ev_on(ev_on),
        .ev_ch(ev_ch), .ev_key(ev_key), .ev_vel(ev_vel), .base_ch(base_ch), .voice_free(voice_free),
        .note_on(non[0]), .note_off(noff[0]), .steal(stl[0]), .off_note_error(err[0]),
        .cur_key_adr(adr[0]), .cur_key_val(kval[0]), .cur_vel_on(von[0]), .cur_vel_off(voff[0]),
        .cur_ch(cch[0]), .keys_on(kon[0]), .active_keys(act[0]));

    midi_voice_alloc #(.VOICES(NV), .CHANNELS(NCH), .STEAL_EN(0)) u_dut_nosteal (
        .CLOCK_25(clk), .iRST(rst), .ev_valid(ev_valid), .ev_ready(rdy[1]), .ev_on(ev_on),
        .ev_ch(ev_ch), .ev_key(ev_key), .ev_vel(ev_vel), .base_ch(base_ch), .voice_free(voice_free),
        .note_on(non[1]), .note_off(noff[1]), .steal(stl[1]), .off_note_error(err[1]),
        .cur_key_adr(adr[1]), .cur_key_val(kval[1]), .cur_vel_on(von[1]), .cur_vel_off(voff[1]),
        .cur_ch(cch[1]), .keys_on(kon[1]), .active_keys(act[1]));

    int total = 0;
    int bad   = 0;

    // Reference model; index 0 steals, index 1 drops. m_lru[s][0] is newest, [NV-1] oldest.
    bit       m_held [2][NV];
    bit [6:0] m_key  [2][NV];
    bit [3:0] m_ch   [2][NV];
    int       m_lru  [2][NV];
    int       e_adr [2], e_kval [2], e_von [2], e_voff [2], e_ch [2];
    bit       e_non [2], e_noff [2], e_stl [2], e_err [2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic logic [7:0] held_vec(input int s);
        logic [7:0] v;
        for (int i = 0; i < NV; i++) v[i] = m_held[s][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NV; i++) begin
                m_held[s][i] = 1'b0;
                m_key[s][i]  = 7'd0;
                m_ch[s][i]   = 4'd0;
                m_lru[s][i]  = i;
            end
            e_adr[s] = 0; e_kval[s] = 0; e_von[s] = 0; e_voff[s] = 0; e_ch[s] = 0;
            e_non[s] = 1'b0; e_noff[s] = 1'b0; e_stl[s] = 1'b0; e_err[s] = 1'b0;
        end
    endtask

    task automatic model_commit(input int s, input bit on, input logic [3:0] ch,
                                input logic [6:0] key, input logic [6:0] vel, input logic [7:0] vf);
        int mi, fi, v, p;
        e_non[s] = 1'b0; e_noff[s] = 1'b0; e_stl[s] = 1'b0; e_err[s] = 1'b0;
        mi = -1;
        fi = -1;
        for (int i = 0; i < NV; i++) begin
            if (mi < 0 && m_held[s][i] && m_key[s][i] == key && m_ch[s][i] == ch) mi = i;
            if (fi < 0 && vf[i] && !m_held[s][i]) fi = i;
        end
        if (on && vel != 7'd0) begin
            if (mi >= 0) v = mi;
            else if (fi >= 0) v = fi;
            else if (s == 0) begin v = m_lru[s][NV-1]; e_stl[s] = 1'b1; end
            else v = -1;
            if (v < 0) begin
                e_err[s] = 1'b1;
            end else begin
                p = 0;
                for (int i = 0; i < NV; i++) if (m_lru[s][i] == v) p = i;
                for (int i = p; i > 0; i--) m_lru[s][i] = m_lru[s][i-1];
                m_lru[s][0] = v;
                m_held[s][v] = 1'b1;
                m_key[s][v]  = key;
                m_ch[s][v]   = ch;
                e_non[s] = 1'b1; e_adr[s] = v; e_kval[s] = key; e_von[s] = vel; e_ch[s] = ch;
            end
        end else if (mi >= 0) begin
            m_held[s][mi] = 1'b0;
            e_noff[s] = 1'b1; e_adr[s] = mi; e_voff[s] = vel; e_ch[s] = ch;
        end else begin
            e_err[s] = 1'b1;
        end
    endtask

    task automatic check_outputs();
        for (int s = 0; s < 2; s++) begin
            check_val($sformatf("note_on[%0d]", s), non[s], e_non[s]);
            check_val($sformatf("note_off[%0d]", s), noff[s], e_noff[s]);
            check_val($sformatf("steal[%0d]", s), stl[s], e_stl[s]);
            check_val($sformatf("off_note_error[%0d]", s), err[s], e_err[s]);
            check_val($sformatf("cur_key_adr[%0d]", s), adr[s], e_adr[s]);
            check_val($sformatf("cur_key_val[%0d]", s), kval[s], e_kval[s]);
            check_val($sformatf("cur_vel_on[%0d]", s), von[s], e_von[s]);
            check_val($sformatf("cur_vel_off[%0d]", s), voff[s], e_voff[s]);
            check_val($sformatf("cur_ch[%0d]", s), cch[s], e_ch[s]);
            check_val($sformatf("keys_on[%0d]", s), kon[s], held_vec(s));
            check_val($sformatf("active_keys[%0d]", s), act[s], $countones(held_vec(s)));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ready"}, rdy, 0);
        check_val({tag, "_strobes"}, {non, noff, stl, err}, 0);
        for (int s = 0; s < 2; s++) begin
            check_val({tag, "_cur"}, {adr[s], kval[s], von[s], voff[s], cch[s]}, 0);
            check_val({tag, "_keys"}, {kon[s], act[s]}, 0);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (rdy != 2'b11 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("ready_wait", rdy, 2'b11);
    endtask

    task automatic run_event(input bit on, input logic [3:0] ch, input logic [6:0] key,
                             input logic [6:0] vel, input logic [3:0] base, input logic [7:0] vf);
        logic [3:0] off;
        voice_free = vf;
        wait_ready();
        ev_on = on; ev_ch = ch; ev_key = key; ev_vel = vel; base_ch = base; ev_valid = 1'b1;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        off = ch - base;
        if (off >= NCH) begin
            check_val("drop_ready", rdy, 2'b11);
            check_val("drop_strobes", {non, noff, stl, err}, 0);
            check_val("drop_keys", kon[0], held_vec(0));
        end else begin
            model_commit(0, on, ch, key, vel, vf);
            model_commit(1, on, ch, key, vel, vf);
            for (int c = 1; c <= NV; c++) begin
                check_val("scan_strobes", {non, noff, stl, err}, 0);
                check_val("scan_ready", rdy, 0);
                @(posedge clk); #1;
            end
            check_outputs();
            @(posedge clk); #1;
            check_val("post_strobes", {non, noff, stl, err}, 0);
            check_val("post_ready", rdy, 2'b11);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] base, ch;
        rst = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_ch = 4'd0; ev_key = 7'd0; ev_vel = 7'd0;
        base_ch = 4'd0; voice_free = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        model_reset();

        run_event(1'b1, 4'd0, 7'd60, 7'd100, 4'd0, 8'hFF);
        run_event(1'b1, 4'd0, 7'd64, 7'd80, 4'd0, 8'hFF);
        run_event(1'b0, 4'd0, 7'd60, 7'd40, 4'd0, 8'hFF);
        run_event(1'b1, 4'd0, 7'd64, 7'd0, 4'd0, 8'hFF);
        run_event(1'b1, 4'd0, 7'd64, 7'd90, 4'd0, 8'hFF);
        run_event(1'b1, 4'd0, 7'd64, 7'd91, 4'd0, 8'hFF);

        do_reset();
        for (int k = 0; k < NV; k++) run_event(1'b1, 4'd0, 7'(60 + k), 7'd50, 4'd0, 8'hFF);
        run_event(1'b1, 4'd0, 7'd70, 7'd100, 4'd0, 8'h00);
        run_event(1'b1, 4'd0, 7'd71, 7'd101, 4'd0, 8'h00);
        run_event(1'b0, 4'd0, 7'd99, 7'd10, 4'd0, 8'hFF);

        voice_free = 8'hFF;
        wait_ready();
        ev_on = 1'b1; ev_ch = 4'd0; ev_key = 7'd61; ev_vel = 7'd30; base_ch = 4'd0; ev_valid = 1'b1;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_all_zero("mid_scan_reset");
        @(posedge clk); #1;
        check_val("after_reset_ready", rdy, 2'b11);
        check_val("after_reset_strobes", {non, noff, stl, err}, 0);

        run_event(1'b1, 4'd3, 7'd62, 7'd70, 4'd2, 8'hFF);
        run_event(1'b1, 4'd4, 7'd63, 7'd70, 4'd2, 8'hFF);
        run_event(1'b1, 4'd0, 7'd63, 7'd5, 4'd15, 8'hFF);
        run_event(1'b0, 4'd3, 7'd62, 7'd0, 4'd2, 8'hFF);

        for (int n = 0; n < 200; n++) begin
            base = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd15;
            ch = ($urandom_range(0, 5) == 0) ? 4'(base + 4'($urandom_range(2, 15)))
                                             : 4'(base + 4'($urandom_range(0, 1)));
            case ($urandom_range(0, 3))
                0:       voice_free = 8'h00;
                1:       voice_free = 8'hFF;
                default: voice_free = 8'($urandom_range(0, 255));
            endcase
            run_event($urandom_range(0, 2) != 0, ch, 7'(60 + $urandom_range(0, 11)),
                      ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
                      base, voice_free);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
